// File: rtl/risc16_pkg.sv
// rtl/risc16_pkg.sv - shared types and constants for the risc16 memory arbiter
package risc16_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_DONE   = 2'd2
   } arb_state_t;

   typedef logic master_id_t;

   localparam logic [15:0] ADDR_ALIGN_MASK = 16'hfffe;

endpackage

// File: rtl/risc16_rr_pick.sv
// rtl/risc16_rr_pick.sv - combinational two-way round-robin pick
module risc16_rr_pick
   import risc16_pkg::*;
(
   input  logic [1:0] req,
   input  master_id_t last,
   output logic       grant_valid,
   output master_id_t grant_id
);

   always_comb begin
      grant_valid = |req;
      grant_id    = 1'b0;
      if (&req) begin
         grant_id = ~last;
      end else if (req[1]) begin
         grant_id = 1'b1;
      end
   end

endmodule

// File: rtl/risc16_mem_arbiter.sv
// rtl/risc16_mem_arbiter.sv - two-master round-robin arbiter for the risc16 memory port
module risc16_mem_arbiter
   import risc16_pkg::*;
#(
   parameter int AW = 16,
   parameter int DW = 16,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m1_req,
   input  logic          m0_we,
   input  logic          m1_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [DW-1:0] m1_wdata,
   output logic          m0_ack,
   output logic          m1_ack,
   output logic [DW-1:0] m0_rdata,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_oe,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic [CW-1:0] m0_grants,
   output logic [CW-1:0] m1_grants
);

   arb_state_t    state_q, state_d;
   master_id_t    owner_q, last_q;
   logic [AW-1:0] addr_q;
   logic          we_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] m0_rdata_q, m1_rdata_q;
   logic          m0_ack_q, m1_ack_q;
   logic [CW-1:0] m0_grants_q, m1_grants_q;
   logic          grant_valid;
   master_id_t    grant_id;

   risc16_rr_pick u_pick (
      .req         ({m1_req, m0_req}),
      .last        (last_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:   if (grant_valid) state_d = ARB_ACCESS;
         ARB_ACCESS: state_d = ARB_DONE;
         ARB_DONE:   state_d = ARB_IDLE;
         default:    state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
         m0_ack_q    <= 1'b0;
         m1_ack_q    <= 1'b0;
         m0_grants_q <= '0;
         m1_grants_q <= '0;
      end else begin
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (grant_valid) begin
                  owner_q <= grant_id;
                  addr_q  <= grant_id ? m1_addr  : m0_addr;
                  we_q    <= grant_id ? m1_we    : m0_we;
                  wdata_q <= grant_id ? m1_wdata : m0_wdata;
               end
            end
            ARB_ACCESS: begin
               // Read data is only valid while mem_oe, so it is captured here, not in DONE.
               if (!we_q) begin
                  if (owner_q) m1_rdata_q <= mem_rdata;
                  else         m0_rdata_q <= mem_rdata;
               end
               m0_ack_q <= (owner_q == 1'b0);
               m1_ack_q <= (owner_q == 1'b1);
            end
            ARB_DONE: begin
               if (owner_q) m1_grants_q <= m1_grants_q + 1'b1;
               else         m0_grants_q <= m0_grants_q + 1'b1;
               last_q <= owner_q;
            end
            default: ;
         endcase
      end
   end

   // addr_q/wdata_q only change on a new grant, so the port holds its last values.
   assign mem_addr  = addr_q & AW'(ADDR_ALIGN_MASK);
   assign mem_wdata = wdata_q;
   assign mem_oe    = (state_q == ARB_ACCESS) && !we_q;
   assign mem_we    = (state_q == ARB_ACCESS) && we_q && !rst;
   assign busy      = (state_q != ARB_IDLE);
   assign m0_ack    = m0_ack_q;
   assign m1_ack    = m1_ack_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign m0_grants = m0_grants_q;
   assign m1_grants = m1_grants_q;

endmodule

// File: doc/risc16_mem_arbiter.md
# risc16_mem_arbiter

Two-master arbiter that shares the single 16-bit memory port of the risc16 system between master 0 (the risc16 core's load/store/fetch path, wrapped in a req/ack adapter) and master 1 (a DMA/loader engine). Requests are arbitrated round-robin, and each winning access is sequenced through a fixed three-state FSM. The block drives the combinational-read, posedge-write memory model with `oe`/`we`. It sits between the masters and the memory/MMIO decode, and MMIO addresses (0x200/0x202) pass through untouched.

## Interface
Parameters:
- `AW`, 16, address width (byte address).
- `DW`, 16, data width.
- `CW`, 8, width of per-master grant counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset rst, synchronous, active-high.
- `m0_req`, `m1_req`  in  1  access request; level, held until ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; stable while req.
- `m0_addr`, `m1_addr`  in  AW  byte address; stable while req.
- `m0_wdata`, `m1_wdata`  in  DW  write data; stable while req.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  DW  read data, valid in ack cycle, held until next completion for that master.
- `mem_addr`  out  AW  memory address, bit 0 forced to 0.
- `mem_wdata`  out  DW  memory write data.
- `mem_oe`  out  1  read enable.
- `mem_we`  out  1  write enable.
- `mem_rdata`  in  DW  combinational read data (valid while `mem_oe`).
- `busy`  out  1  FSM not in ARB_IDLE.
- `m0_grants`, `m1_grants`  out  CW  completed accesses per master, wrap modulo 2^CW.

## Operation
- FSM states: ARB_IDLE, ARB_ACCESS, ARB_DONE.
- ARB_IDLE:
  - If any req is high, pick a winner.
  - Latch the winner's addr/we/wdata into `addr_q`/`we_q`/`wdata_q`, record `owner`, then go to ARB_ACCESS.
  - With no request, stay in ARB_IDLE.
- ARB_ACCESS:
  - Drive `mem_addr = {addr_q[AW-1:1],1'b0}` and `mem_wdata = wdata_q`.
  - `mem_oe = !we_q`, `mem_we = we_q && !rst`.
  - On a read, capture `mem_rdata` into the owner's rdata register.
  - Always go to ARB_DONE.
- ARB_DONE:
  - Assert the owner's ack (registered).
  - Increment the owner's grant counter; counters wrap to 0 after 2^CW-1.
  - Set `last = owner`, go to ARB_IDLE.
- Round-robin selection:
  - If both masters request, grant the master ≠ `last`.
  - If only one requests, grant it regardless of `last`.
  - `last` resets to 1, so master 0 wins the first tie.
- Request sampling:
  - Requests are sampled only in ARB_IDLE.
  - Req/addr/data changes during ARB_ACCESS/ARB_DONE are ignored.
  - A master must deassert req on the edge ending its ack cycle. Req still high in the following ARB_IDLE cycle is a new request.
- Outside ARB_ACCESS: `mem_oe = mem_we = 0`; `mem_addr`/`mem_wdata` hold their last values.
- Reset values: state ARB_IDLE; all acks 0; `mem_oe`/`mem_we` 0; `mem_addr`, `mem_wdata`, rdata regs, grant counters 0; `busy` 0; `last` 1.
- Reset mid-operation:
  - Any state returns to ARB_IDLE; no ack is issued and no counter increments.
  - `mem_we` is gated by `rst`, so a write in ARB_ACCESS during the reset cycle is suppressed.

## Timing
- Request high in IDLE cycle N → ARB_ACCESS in cycle N+1 (memory strobe) → ack in cycle N+2 → IDLE in cycle N+3.
- Latency is 2 cycles from sample to ack. Peak throughput is one access per 3 cycles.
- Write commits at the posedge ending cycle N+1.
- Read data is sampled at the same edge and visible on `mX_rdata` in cycle N+2.
- Ack is exactly one cycle wide, and never asserted for both masters in the same cycle.
- Under continuous contention, grants strictly alternate 0,1,0,1…

## Structure
- Shared package `risc16_pkg`:
  - `arb_state_t` enum {ARB_IDLE, ARB_ACCESS, ARB_DONE}.
  - `master_id_t` (1-bit).
  - `ADDR_ALIGN_MASK = 16'hfffe`.
- One sub-module, `risc16_rr_pick`: combinational 2-way round-robin pick from req[1:0] and `last`. Outputs `grant_valid` and `grant_id`.
- FSM, latches, rdata registers and counters stay in the top module.

## Test plan
- Reset then m0 read addr 0x0005, memory word at 0x0004 = 0xA55A → ARB_ACCESS shows `mem_addr` = 0x0004, `mem_oe` = 1; `m0_ack` 2 cycles after sample; `m0_rdata` = 0xA55A; `m0_grants` = 1.
- m1 write addr 0x0010 data 0x1234 → `mem_we` high exactly 1 cycle; memory bytes 0x10/0x11 = 0x12/0x34; `m1_ack` 1 cycle; `m0_ack` stays 0.
- Both req high continuously for 6 accesses after reset → grant order 0,1,0,1,0,1; each counter = 3.
- m1 requests alone 4 times back-to-back (req held only until ack) → 4 acks spaced 3 cycles apart; `m1_grants` = 4.
- Assert rst during an m0 write's ARB_ACCESS cycle (addr 0x0020, data 0xFFFF) → `mem_we` = 0 in that cycle; memory at 0x20 unchanged; no ack; state ARB_IDLE; counters 0.
- 256 m0 accesses → `m0_grants` wraps to 0x00; MMIO address 0x0202 write → `mem_addr` = 0x0202 passed through.
